// File: rtl/cam_pwr_seq_pkg.sv
// cam_pwr_seq_pkg: shared definitions for the camera power sequencer.
//   - state_t      : 3-bit FSM encoding (codes 5-7 unused, recover to PWDN_HOLD)
//   - DEF_*_CYC    : default hold/settle counts for a 100 MHz clock
//   - max3         : helper used by the elaboration-time width check
package cam_pwr_seq_pkg;

  typedef enum logic [2:0] {
    PWDN_HOLD = 3'd0,
    RST_HOLD  = 3'd1,
    SETTLE    = 3'd2,
    READY     = 3'd3,
    SLEEP     = 3'd4
  } state_t;

  localparam int DEF_PWDN_HOLD_CYC   = 500000;   // 5 ms
  localparam int DEF_RESETB_HOLD_CYC = 100000;   // 1 ms
  localparam int DEF_SETTLE_CYC      = 2000000;  // 20 ms
  localparam int DEF_CNT_W           = 22;

  function automatic longint max3(input longint a, input longint b, input longint c);
    longint m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cam_pwr_seq_if.sv
// cam_pwr_seq_if: control/status bundle between the sequencer and its user.
//   i_restart      : single-cycle restart pulse (master -> slave)
//   i_pwdn_req     : sleep request level (master -> slave)
//   o_cam_pwdn     : PWDN pin, active high (slave -> master)
//   o_cam_resetb   : RESETB pin, active low (slave -> master)
//   o_ready        : sensor accessible over SCCB (slave -> master)
//   o_state, o_restart_cnt : debug taps, only with CAM_PWR_SEQ_DBG_EN
interface cam_pwr_seq_if;
  logic       i_restart;
  logic       i_pwdn_req;
  logic       o_cam_pwdn;
  logic       o_cam_resetb;
  logic       o_ready;
`ifdef CAM_PWR_SEQ_DBG_EN
  logic [2:0] o_state;
  logic [7:0] o_restart_cnt;
`endif

  modport master (
    output i_restart, i_pwdn_req,
    input  o_cam_pwdn, o_cam_resetb, o_ready
`ifdef CAM_PWR_SEQ_DBG_EN
    , input o_state, o_restart_cnt
`endif
  );

  modport slave (
    input  i_restart, i_pwdn_req,
    output o_cam_pwdn, o_cam_resetb, o_ready
`ifdef CAM_PWR_SEQ_DBG_EN
    , output o_state, o_restart_cnt
`endif
  );
endinterface

// File: rtl/cam_seq_timer.sv
// cam_seq_timer: CNT_W-wide up-counter for the timed sequencer states.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force the count to 0 on this edge
//   tc       : terminal count (N-1)
//   done     : high while count == tc; the counter wraps to 0 on that edge
module cam_seq_timer #(
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] tc,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = (cnt == tc);

  always_ff @(posedge clk) begin
    if (rst || clr || done) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cam_pwr_seq.sv
// cam_pwr_seq: OV5642 power-up / reset sequencer.
//   i_clk       : system clock
//   i_sync_rst  : synchronous active-high reset
//   bus (slave) : i_restart, i_pwdn_req in; o_cam_pwdn, o_cam_resetb, o_ready out
// Sequence: PWDN_HOLD -> RST_HOLD -> SETTLE -> READY, with READY <-> SLEEP
// via i_pwdn_req (wake goes through a full SETTLE). All outputs are registered
// from the next state so they change on the same edge as the state register.
// Optional build macro CAM_PWR_SEQ_DBG_EN adds o_state and o_restart_cnt.
module cam_pwr_seq
  import cam_pwr_seq_pkg::*;
#(
  parameter int PWDN_HOLD_CYC   = DEF_PWDN_HOLD_CYC,
  parameter int RESETB_HOLD_CYC = DEF_RESETB_HOLD_CYC,
  parameter int SETTLE_CYC      = DEF_SETTLE_CYC,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic        i_clk,
  input  logic        i_sync_rst,
  cam_pwr_seq_if.slave bus
);

  if (PWDN_HOLD_CYC < 1 || RESETB_HOLD_CYC < 1 || SETTLE_CYC < 1) begin : g_bad_cyc
    $error("cam_pwr_seq: all *_CYC parameters must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 62 ||
      (64'sd1 <<< CNT_W) <= max3(PWDN_HOLD_CYC, RESETB_HOLD_CYC, SETTLE_CYC)) begin : g_bad_w
    $error("cam_pwr_seq: CNT_W too narrow for the largest *_CYC value");
  end

  localparam logic [CNT_W-1:0] TC_PWDN   = CNT_W'(PWDN_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TC_RESETB = CNT_W'(RESETB_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TC_SETTLE = CNT_W'(SETTLE_CYC - 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] tc;
  logic             timed, tmr_clr, done;

  // Timer only runs in the three timed states; elsewhere it is held at 0 so a
  // wake from SLEEP enters SETTLE with a fresh count.
  always_comb begin
    timed = 1'b0;
    tc    = TC_SETTLE;
    case (state)
      PWDN_HOLD: begin timed = 1'b1; tc = TC_PWDN;   end
      RST_HOLD:  begin timed = 1'b1; tc = TC_RESETB; end
      SETTLE:    begin timed = 1'b1; tc = TC_SETTLE; end
      default:   ;
    endcase
  end

  assign tmr_clr = bus.i_restart || !timed;

  cam_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (i_clk),
    .rst  (i_sync_rst),
    .clr  (tmr_clr),
    .tc   (tc),
    .done (done)
  );

  always_comb begin
    nxt = state;
    if (bus.i_restart) nxt = PWDN_HOLD;
    else begin
      case (state)
        PWDN_HOLD: if (done) nxt = RST_HOLD;
        RST_HOLD:  if (done) nxt = SETTLE;
        SETTLE:    if (done) nxt = READY;
        READY:     if (bus.i_pwdn_req)  nxt = SLEEP;
        SLEEP:     if (!bus.i_pwdn_req) nxt = SETTLE;
        default:   nxt = PWDN_HOLD;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state            <= PWDN_HOLD;
      bus.o_cam_pwdn   <= 1'b1;
      bus.o_cam_resetb <= 1'b0;
      bus.o_ready      <= 1'b0;
    end else begin
      state            <= nxt;
      bus.o_cam_pwdn   <= (nxt == PWDN_HOLD) || (nxt == SLEEP);
      bus.o_cam_resetb <= (nxt == SETTLE) || (nxt == READY) || (nxt == SLEEP);
      bus.o_ready      <= (nxt == READY);
    end
  end

`ifdef CAM_PWR_SEQ_DBG_EN
  logic [7:0] restart_cnt;

  always_ff @(posedge i_clk) begin
    if (i_sync_rst)                              restart_cnt <= '0;
    else if (bus.i_restart && restart_cnt != 8'hFF) restart_cnt <= restart_cnt + 8'd1;
  end

  assign bus.o_state       = state;
  assign bus.o_restart_cnt = restart_cnt;
`endif

endmodule
